// File: rtl/alu_pkg.sv
// Shared encodings for the pipelined ALU: opcodes, FSM states, and flag-bit positions.
package alu_pkg;

   localparam logic [2:0] OP_OR  = 3'd0;
   localparam logic [2:0] OP_AND = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   localparam int NFLAGS = 4;
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_pipe_if.sv
// Request/response bundle between an ALU requester (master) and alu_pipe (slave).
interface alu_pipe_if #(
   parameter int WIDTH = 16
);

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             zero_x;
   logic             zero_y;
   logic             negate_output;
   logic [2:0]       opcode;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] result;
   logic             flag_z;
   logic             flag_n;
   logic             flag_c;
   logic             flag_v;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output x, y, zero_x, zero_y, negate_output, opcode, in_valid, out_ready,
      input  in_ready, result, flag_z, flag_n, flag_c, flag_v, out_valid
   );

   modport slave (
      input  x, y, zero_x, zero_y, negate_output, opcode, in_valid, out_ready,
      output in_ready, result, flag_z, flag_n, flag_c, flag_v, out_valid
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per clock.
// done_o is high during the final step; the product outputs are valid in that same cycle.
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] prod_lo_o,
   output logic [WIDTH-1:0] prod_hi_o
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;
   logic               last;

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last  = busy_q && (cnt_q == CW'(WIDTH - 1));

   assign done_o    = last;
   assign prod_lo_o = acc_d[WIDTH-1:0];
   assign prod_hi_o = acc_d[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= {{WIDTH{1'b0}}, a_i};
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CW'(1);
         if (last) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, multi-cycle MUL via alu_mul_seq.
//
// state   | meaning
// IDLE    | no result pending, ready for a request
// BUSY    | MUL in progress, requests ignored
// HOLD    | result and flags presented with out_valid=1
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_pipe_if.slave bus
);

   localparam int SHW = $clog2(WIDTH);

   state_e              state_q;
   logic [WIDTH-1:0]    result_q;
   logic [NFLAGS-1:0]   flags_q;
   logic                out_valid_q;
   logic                negate_q;

   logic                in_ready;
   logic                accept;
   logic                mul_start;
   logic [WIDTH-1:0]    xa;
   logic [WIDTH-1:0]    ya;
   logic [SHW-1:0]      sh;
   logic [WIDTH:0]      sum;
   logic [WIDTH:0]      diff;
   logic [WIDTH:0]      shl_ext;
   logic [WIDTH:0]      shr_ext;
   logic [WIDTH-1:0]    raw;
   logic                carry;
   logic                ovf;
   logic [WIDTH-1:0]    res_d;
   logic [NFLAGS-1:0]   flags_d;

   logic                mul_done;
   logic [WIDTH-1:0]    prod_lo;
   logic [WIDTH-1:0]    prod_hi;
   logic [WIDTH-1:0]    mul_res_d;
   logic [NFLAGS-1:0]   mul_flags_d;

   function automatic logic [NFLAGS-1:0] mk_flags(input logic [WIDTH-1:0] r,
                                                   input logic c, input logic v);
      logic [NFLAGS-1:0] f;
      f         = '0;
      f[FLAG_Z] = (r == '0);
      f[FLAG_N] = r[WIDTH-1];
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign mul_start = accept && (bus.opcode == OP_MUL);

   assign xa = bus.zero_x ? '0 : bus.x;
   assign ya = bus.zero_y ? '0 : bus.y;
   assign sh = ya[SHW-1:0];

   always_comb begin
      sum     = {1'b0, xa} + {1'b0, ya};
      diff    = {1'b0, xa} - {1'b0, ya};
      // One spare bit on the shift vectors catches the last bit shifted out.
      shl_ext = {1'b0, xa} << sh;
      shr_ext = {xa, 1'b0} >> sh;
      raw     = '0;
      carry   = 1'b0;
      ovf     = 1'b0;
      case (bus.opcode)
         OP_OR:  raw = xa | ya;
         OP_AND: raw = xa & ya;
         OP_ADD: begin
            raw   = sum[WIDTH-1:0];
            carry = sum[WIDTH];
            ovf   = (xa[WIDTH-1] == ya[WIDTH-1]) && (sum[WIDTH-1] != xa[WIDTH-1]);
         end
         OP_SUB: begin
            raw   = diff[WIDTH-1:0];
            carry = diff[WIDTH];
            ovf   = (xa[WIDTH-1] != ya[WIDTH-1]) && (diff[WIDTH-1] != xa[WIDTH-1]);
         end
         OP_XOR: raw = xa ^ ya;
         OP_SHL: begin
            raw   = shl_ext[WIDTH-1:0];
            carry = shl_ext[WIDTH];
         end
         OP_SHR: begin
            raw   = shr_ext[WIDTH:1];
            carry = shr_ext[0];
         end
         default: raw = '0;
      endcase
      res_d   = bus.negate_output ? ~raw : raw;
      flags_d = mk_flags(res_d, carry, ovf);
   end

   assign mul_res_d   = negate_q ? ~prod_lo : prod_lo;
   assign mul_flags_d = mk_flags(mul_res_d, |prod_hi, 1'b0);

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (xa),
      .b_i       (ya),
      .done_o    (mul_done),
      .prod_lo_o (prod_lo),
      .prod_hi_o (prod_hi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         result_q    <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         negate_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_HOLD: begin
               if (accept) begin
                  if (bus.opcode == OP_MUL) begin
                     state_q     <= ST_BUSY;
                     out_valid_q <= 1'b0;
                     negate_q    <= bus.negate_output;
                  end else begin
                     state_q     <= ST_HOLD;
                     out_valid_q <= 1'b1;
                     result_q    <= res_d;
                     flags_q     <= flags_d;
                  end
               end else if ((state_q == ST_HOLD) && bus.out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (mul_done) begin
                  state_q     <= ST_HOLD;
                  out_valid_q <= 1'b1;
                  result_q    <= mul_res_d;
                  flags_q     <= mul_flags_d;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.flag_z    = flags_q[FLAG_Z];
   assign bus.flag_n    = flags_q[FLAG_N];
   assign bus.flag_c    = flags_q[FLAG_C];
   assign bus.flag_v    = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=16 with hand-computed expectations.
module tb_alu_pipe;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;

   alu_pipe_if #(.WIDTH(16)) bus ();

   alu_pipe #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] flags();
      return {bus.flag_v, bus.flag_c, bus.flag_n, bus.flag_z};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic zx, input logic zy, input logic neg);
      bus.opcode        = op;
      bus.x             = a;
      bus.y             = b;
      bus.zero_x        = zx;
      bus.zero_y        = zy;
      bus.negate_output = neg;
      bus.in_valid      = 1'b1;
   endtask

   // expected flags given as {V,C,N,Z}
   task automatic op1(input string tag, input logic [2:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic zx, input logic zy, input logic neg,
                      input logic [15:0] er, input logic [3:0] ef);
      drive(op, a, b, zx, zy, neg);
      tick();
      bus.in_valid = 1'b0;
      chk({tag, "_valid"}, bus.out_valid, 1'b1);
      chk({tag, "_result"}, bus.result, er);
      chk({tag, "_flags"}, flags(), ef);
      tick();
   endtask

   task automatic mul_run(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic neg, input logic [15:0] er, input logic [3:0] ef,
                          input bit poke_busy);
      logic early;
      logic ready_seen;
      early      = 1'b0;
      ready_seen = 1'b0;
      drive(3'd7, a, b, 1'b0, 1'b0, neg);
      tick();
      bus.in_valid = 1'b0;
      for (int k = 1; k < 16; k++) begin
         if (poke_busy && k == 3) drive(3'd2, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
         if (poke_busy && k == 6) bus.in_valid = 1'b0;
         if (bus.out_valid !== 1'b0) early = 1'b1;
         if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
         tick();
      end
      if (bus.out_valid !== 1'b0) early = 1'b1;
      chk({tag, "_no_early_valid"}, early, 1'b0);
      chk({tag, "_in_ready_low"}, ready_seen, 1'b0);
      tick();
      chk({tag, "_valid_at_16"}, bus.out_valid, 1'b1);
      chk({tag, "_result"}, bus.result, er);
      chk({tag, "_flags"}, flags(), ef);
      tick();
      chk({tag, "_back_idle"}, bus.out_valid, 1'b0);
   endtask

   initial begin
      logic [15:0] held_r;
      logic        bad;
      n_pass            = 0;
      n_total           = 0;
      bus.x             = '0;
      bus.y             = '0;
      bus.zero_x        = 1'b0;
      bus.zero_y        = 1'b0;
      bus.negate_output = 1'b0;
      bus.opcode        = 3'd0;
      bus.in_valid      = 1'b0;
      bus.out_ready     = 1'b1;
      rst_n             = 1'b1;
      #2 rst_n = 1'b0;
      tick();
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_result", bus.result, 16'h0000);
      chk("rst_flags", flags(), 4'b0000);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rst_in_ready", bus.in_ready, 1'b1);

      op1("add_wrap",  3'd2, 16'hFFFF, 16'h0001, 0, 0, 0, 16'h0000, 4'b0101);
      op1("sub_ovf",   3'd3, 16'h8000, 16'h0001, 0, 0, 0, 16'h7FFF, 4'b1000);
      op1("sub_borrow",3'd3, 16'h0000, 16'h0001, 0, 0, 0, 16'hFFFF, 4'b0110);
      op1("or_zx_neg", 3'd0, 16'h1234, 16'h00FF, 1, 0, 1, 16'hFF00, 4'b0010);
      op1("shl_one",   3'd5, 16'h8001, 16'h0001, 0, 0, 0, 16'h0002, 4'b0100);
      op1("shl_zero",  3'd5, 16'h1234, 16'h0010, 0, 0, 0, 16'h1234, 4'b0000);
      op1("shl_modsh", 3'd5, 16'h4000, 16'h0011, 0, 0, 0, 16'h8000, 4'b0010);
      op1("shr_one",   3'd6, 16'h0003, 16'h0001, 0, 0, 0, 16'h0001, 4'b0100);
      op1("shr_four",  3'd6, 16'h8008, 16'h0004, 0, 0, 0, 16'h0800, 4'b0100);
      op1("xor",       3'd4, 16'hAAAA, 16'hFFFF, 0, 0, 0, 16'h5555, 4'b0000);
      op1("and",       3'd1, 16'hF0F0, 16'h3C3C, 0, 0, 0, 16'h3030, 4'b0000);
      op1("add_ovf",   3'd2, 16'h7FFF, 16'h0001, 0, 0, 0, 16'h8000, 4'b1010);
      op1("add_zy_neg",3'd2, 16'h0005, 16'h7777, 0, 1, 1, 16'hFFFA, 4'b0010);

      mul_run("mul_hi",  16'h0100, 16'h0100, 1'b0, 16'h0000, 4'b0101, 1'b0);
      mul_run("mul_sm",  16'h0003, 16'h0005, 1'b0, 16'h000F, 4'b0000, 1'b1);
      mul_run("mul_neg", 16'h0003, 16'h0005, 1'b1, 16'hFFF0, 4'b0010, 1'b0);

      // backpressure: result must stay put while out_ready is low
      bus.out_ready = 1'b0;
      drive(3'd2, 16'h1234, 16'h1111, 0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_first_result", bus.result, 16'h2345);
      held_r = bus.result;
      bus.x  = 16'hDEAD;
      bus.y  = 16'hBEEF;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", bus.out_valid, 1'b1);
         chk("bp_result", bus.result, 16'h2345);
         chk("bp_flags", flags(), 4'b0000);
         chk("bp_in_ready", bus.in_ready, 1'b0);
      end
      chk("bp_held_copy", held_r, 16'h2345);

      bus.out_ready = 1'b1;
      drive(3'd2, 16'h0001, 16'h0001, 0, 0, 0);
      tick();
      chk("b2b_1", {bus.out_valid, bus.result, flags()}, {1'b1, 16'h0002, 4'b0000});
      drive(3'd2, 16'h00FF, 16'h0001, 0, 0, 0);
      tick();
      chk("b2b_2", {bus.out_valid, bus.result, flags()}, {1'b1, 16'h0100, 4'b0000});
      drive(3'd2, 16'h8000, 16'h8000, 0, 0, 0);
      tick();
      chk("b2b_3", {bus.out_valid, bus.result, flags()}, {1'b1, 16'h0000, 4'b1101});
      drive(3'd2, 16'h1000, 16'h2000, 0, 0, 0);
      tick();
      chk("b2b_4", {bus.out_valid, bus.result, flags()}, {1'b1, 16'h3000, 4'b0000});
      bus.in_valid = 1'b0;
      tick();
      chk("b2b_drain", bus.out_valid, 1'b0);

      // reset during a MUL discards it
      drive(3'd7, 16'h0100, 16'h0100, 0, 0, 0);
      tick();
      bus.in_valid = 1'b0;
      for (int k = 0; k < 7; k++) tick();
      rst_n = 1'b0;
      #1;
      chk("mrst_valid_low", bus.out_valid, 1'b0);
      chk("mrst_result_zero", bus.result, 16'h0000);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("mrst_in_ready", bus.in_ready, 1'b1);
      bad = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.out_valid !== 1'b0) bad = 1'b1;
         tick();
      end
      chk("mrst_no_pulse", bad, 1'b0);
      op1("mrst_add", 3'd2, 16'h0002, 16'h0003, 0, 0, 0, 16'h0005, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal range 4..64).
REQ-002 The block SHALL have derived localparam SHW = $clog2(WIDTH), giving the shift-amount width.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 x, y  input  WIDTH each  operands.
REQ-006 zero_x, zero_y  input  1 each  force the corresponding operand to 0 before the operation.
REQ-007 negate_output  input  1  bitwise-invert the result.
REQ-008 opcode  input  3  operation select.
REQ-009 in_valid  input  1 and in_ready  output  1  request handshake.
REQ-010 result  output  WIDTH  registered result.
REQ-011 flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry/borrow and overflow flags.
REQ-012 out_valid  output  1 and out_ready  input  1  response handshake.

Function
REQ-013 The request SHALL be accepted on a rising edge where in_valid && in_ready; x, y, opcode, zero_x, zero_y and negate_output SHALL be captured only then.
REQ-014 The opcodes SHALL be: 0 OR, 1 AND, 2 ADD, 3 SUB (x-y), 4 XOR, 5 SHL (x << y[SHW-1:0]), 6 SHR logical, 7 MUL (low WIDTH bits of x*y, unsigned).
REQ-015 Opcodes 0-6 SHALL complete in one cycle: out_valid rises on the edge after the accepting edge.
REQ-016 MUL SHALL be iterative shift-add, one bit per cycle: out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-017 FSM states SHALL be IDLE, BUSY (MUL only) and HOLD (out_valid=1). Transitions: IDLE->BUSY on MUL accept; IDLE->HOLD on other accepts; BUSY->HOLD when the bit counter reaches WIDTH-1; HOLD->IDLE on out_ready unless a new request is accepted on the same edge.
REQ-018 in_ready SHALL be (state==IDLE) || (state==HOLD && out_ready), so that back-to-back single-cycle ops sustain one result per cycle.
REQ-019 While out_valid=1 && out_ready=0, result and all flags SHALL be held stable.
REQ-020 flag_c SHALL be: ADD carry-out; SUB borrow (x<y unsigned); SHL/SHR last bit shifted out, or 0 for a zero shift; MUL 1 if the high half of the product is nonzero; 0 for logic ops.
REQ-021 flag_v SHALL be signed overflow for ADD and SUB, and 0 for all other ops.
REQ-022 negate_output SHALL apply after the operation; flag_z and flag_n SHALL reflect the final (possibly inverted) result; flag_c and flag_v SHALL NOT be affected by negation.
REQ-023 in_valid while in_ready=0 SHALL be ignored (not queued), and the requester SHALL hold its request stable.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, out_valid=0, result=0, all flags=0, MUL counter and accumulator=0.
REQ-025 Reset during BUSY or HOLD SHALL discard the operation with no out_valid pulse; in_ready SHALL be 1 on the first edge after rst_n deasserts.

Structure
REQ-026 Package alu_pkg SHALL hold the opcode localparams, the FSM state encoding and the flag-bit indices.
REQ-027 The MUL datapath SHALL be sub-module alu_mul_seq (start, operands, done, product low/high), parameterised by WIDTH.

Verification (WIDTH=16)
REQ-028 ADD x=0xFFFF y=0x0001 -> next cycle result=0x0000, Z=1, C=1, V=0, N=0.
REQ-029 SUB x=0x8000 y=0x0001 -> 0x7FFF, V=1, C=0; SUB x=0x0000 y=0x0001 -> 0xFFFF, C=1, N=1.
REQ-030 MUL x=0x0100 y=0x0100 -> out_valid exactly 16 cycles after accept, result=0x0000, C=1, Z=1; in_ready=0 throughout.
REQ-031 OR with zero_x=1, y=0x00FF, negate_output=1 -> 0xFF00, N=1, Z=0; SHL x=0x8001 y=1 -> 0x0002, C=1.
REQ-032 Backpressure: out_ready low for 5 cycles after a result -> result and flags constant, in_ready=0; then 4 back-to-back ADDs with out_ready=1 -> 4 consecutive results on consecutive cycles.
REQ-033 Assert rst_n low at cycle 7 of a MUL -> out_valid stays 0; in_ready=1 after release; the next ADD 2+3 -> 0x0005.
